// File: rtl/note_judge.sv
// ---------------------------------------------------------------------------
// note_judge -- rhythm-game judgement stage.
//
// Holds upcoming chart notes in four per-lane FIFOs. On every new_frame
// strobe taken in IDLE it samples the key-press edges and the song time,
// then scans lanes 0..3 (one per cycle). Each scanned lane emits at most
// one judgement and updates score / combo / max_combo.
//
// Optional feature macro: NOTE_JUDGE_AUTOPLAY_EN
//   defined   : a lane counts as pressed whenever 0 <= delta <= GOOD_WIN,
//               so DFJK is ignored.
//   undefined : normal key-driven judgement.
//
// Handshake (chart loader push port): an entry is transferred on every
// clock edge where note_valid && note_ready; note_ready is combinational
// and depends only on the fill level of queue[note_lane].
//
// Ports:
//   clk, reset         clock, asynchronous active-high reset
//   clear              synchronous flush (queues, score, combos, overrun)
//   new_frame          one-cycle frame strobe
//   DFJK[3:0]          lane key levels, bit0 = D
//   un_time[15:0]      song time in frame ticks
//   note_valid/lane/time, note_ready   chart push port
//   judge_valid/lane/grade             registered judgement pulse
//   score[19:0], combo[9:0], max_combo[9:0]
//   overrun            sticky: strobe arrived during a scan
//   busy               FSM state (high while scanning)
// ---------------------------------------------------------------------------
module note_judge #(
    parameter int DEPTH       = 16,
    parameter int PERFECT_WIN = 1,
    parameter int GREAT_WIN   = 3,
    parameter int GOOD_WIN    = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        new_frame,
    input  logic [3:0]  DFJK,
    input  logic [15:0] un_time,
    input  logic        note_valid,
    input  logic [1:0]  note_lane,
    input  logic [15:0] note_time,
    output logic        note_ready,
    output logic        judge_valid,
    output logic [1:0]  judge_lane,
    output logic [1:0]  judge_grade,
    output logic [19:0] score,
    output logic [9:0]  combo,
    output logic [9:0]  max_combo,
    output logic        overrun,
    output logic        busy
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]         L_FULL   = (AW+1)'(DEPTH);
    localparam logic signed [16:0]  L_GOOD_P = 17'(GOOD_WIN);
    localparam logic signed [16:0]  L_GOOD_N = -L_GOOD_P;
    localparam logic [16:0]         L_PERF   = 17'(PERFECT_WIN);
    localparam logic [16:0]         L_GREAT  = 17'(GREAT_WIN);

    typedef enum logic {S_IDLE, S_SCAN} state_t;

    state_t r_state, w_state_nxt;

    // Per-lane FIFOs of target times
    logic [15:0]  r_mem  [0:3][0:DEPTH-1];
    logic [AW-1:0] r_wptr [0:3];
    logic [AW-1:0] r_rptr [0:3];
    logic [AW:0]   r_cnt  [0:3];

    // Frame context captured on the strobe
    logic [3:0]  r_prev_keys;
    logic [3:0]  r_press;
    logic [15:0] r_now;
    logic [1:0]  r_lane;

    logic        r_judge_valid;
    logic [1:0]  r_judge_lane;
    logic [1:0]  r_judge_grade;
    logic [19:0] r_score;
    logic [9:0]  r_combo;
    logic [9:0]  r_max_combo;
    logic        r_overrun;

    logic               w_push;
    logic [15:0]        w_head_time;
    logic               w_nonempty;
    logic signed [16:0] w_delta;
    logic [16:0]        w_abs;
    logic               w_late;
    logic               w_in_win;
    logic               w_press;
    logic               w_scan;
    logic               w_miss;
    logic               w_hit;
    logic               w_pop;
    logic [1:0]         w_grade;
    logic [8:0]         w_inc;
    logic [20:0]        w_sum;
    logic [19:0]        w_score_nxt;
    logic [9:0]         w_combo_nxt;
    logic [9:0]         w_max_nxt;

    assign note_ready = (r_cnt[note_lane] != L_FULL);
    assign w_push     = note_valid && note_ready;

    // ------------------------------------------------------------------
    // Evaluation of the lane currently being scanned
    // ------------------------------------------------------------------
    assign w_scan      = (r_state == S_SCAN);
    assign w_head_time = r_mem[r_lane][r_rptr[r_lane]];
    assign w_nonempty  = (r_cnt[r_lane] != '0);
    // Positive delta: the note is in the past (player is late)
    assign w_delta     = $signed({1'b0, r_now}) - $signed({1'b0, w_head_time});
    assign w_late      = (w_delta > L_GOOD_P);
    assign w_in_win    = (w_delta >= L_GOOD_N) && (w_delta <= L_GOOD_P);

`ifdef NOTE_JUDGE_AUTOPLAY_EN
    assign w_press = !w_delta[16] && !w_late;
`else
    assign w_press = r_press[r_lane];
`endif

    assign w_miss = w_scan && w_nonempty && w_late;
    assign w_hit  = w_scan && w_nonempty && w_press && w_in_win;
    assign w_pop  = w_miss || w_hit;

    always_comb begin
        w_abs = w_delta;
        if (w_delta[16]) begin
            w_abs = -w_delta;
        end
    end

    always_comb begin
        w_grade = 2'd0;
        if (!w_miss) begin
            if (w_abs <= L_PERF) begin
                w_grade = 2'd3;
            end else if (w_abs <= L_GREAT) begin
                w_grade = 2'd2;
            end else begin
                w_grade = 2'd1;
            end
        end
    end

    always_comb begin
        w_inc = 9'd0;
        case (w_grade)
            2'd3:    w_inc = 9'd300;
            2'd2:    w_inc = 9'd200;
            2'd1:    w_inc = 9'd100;
            default: w_inc = 9'd0;
        endcase
    end

    assign w_sum       = {1'b0, r_score} + {12'd0, w_inc};
    assign w_score_nxt = w_sum[20] ? 20'hFFFFF : w_sum[19:0];
    assign w_combo_nxt = w_miss ? 10'd0 :
                         (r_combo == 10'h3FF) ? r_combo : r_combo + 10'd1;
    assign w_max_nxt   = (w_combo_nxt > r_max_combo) ? w_combo_nxt : r_max_combo;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (clear) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: if (new_frame) w_state_nxt = S_SCAN;
                S_SCAN: if (r_lane == 2'd3) w_state_nxt = S_IDLE;
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Queue storage (no reset needed: pointers define validity)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_push && !clear) begin
            r_mem[note_lane][r_wptr[note_lane]] <= note_time;
        end
    end

    // ------------------------------------------------------------------
    // Queue pointers, frame context, judgement and score registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int l = 0; l < 4; l++) begin
                r_wptr[l] <= '0;
                r_rptr[l] <= '0;
                r_cnt[l]  <= '0;
            end
            r_prev_keys   <= '0;
            r_press       <= '0;
            r_now         <= '0;
            r_lane        <= '0;
            r_judge_valid <= 1'b0;
            r_judge_lane  <= '0;
            r_judge_grade <= '0;
            r_score       <= '0;
            r_combo       <= '0;
            r_max_combo   <= '0;
            r_overrun     <= 1'b0;
        end else if (clear) begin
            for (int l = 0; l < 4; l++) begin
                r_wptr[l] <= '0;
                r_rptr[l] <= '0;
                r_cnt[l]  <= '0;
            end
            r_prev_keys   <= '0;
            r_press       <= '0;
            r_now         <= '0;
            r_lane        <= '0;
            r_judge_valid <= 1'b0;
            r_judge_lane  <= '0;
            r_judge_grade <= '0;
            r_score       <= '0;
            r_combo       <= '0;
            r_max_combo   <= '0;
            r_overrun     <= 1'b0;
        end else begin
            for (int l = 0; l < 4; l++) begin
                logic v_push_l;
                logic v_pop_l;
                v_push_l = w_push && (note_lane == 2'(l));
                v_pop_l  = w_pop && (r_lane == 2'(l));
                if (v_push_l) r_wptr[l] <= r_wptr[l] + 1'b1;
                if (v_pop_l)  r_rptr[l] <= r_rptr[l] + 1'b1;
                if (v_push_l && !v_pop_l) begin
                    r_cnt[l] <= r_cnt[l] + 1'b1;
                end else if (v_pop_l && !v_push_l) begin
                    r_cnt[l] <= r_cnt[l] - 1'b1;
                end
            end

            if (new_frame) begin
                if (r_state == S_IDLE) begin
                    r_press     <= DFJK & ~r_prev_keys;
                    r_prev_keys <= DFJK;
                    r_now       <= un_time;
                    r_lane      <= 2'd0;
                end else begin
                    r_overrun <= 1'b1;
                end
            end

            if (w_scan) begin
                r_lane <= r_lane + 2'd1;
            end

            r_judge_valid <= w_pop;
            if (w_pop) begin
                r_judge_lane  <= r_lane;
                r_judge_grade <= w_grade;
                r_score       <= w_score_nxt;
                r_combo       <= w_combo_nxt;
                r_max_combo   <= w_max_nxt;
            end
        end
    end

    assign judge_valid = r_judge_valid;
    assign judge_lane  = r_judge_lane;
    assign judge_grade = r_judge_grade;
    assign score       = r_score;
    assign combo       = r_combo;
    assign max_combo   = r_max_combo;
    assign overrun     = r_overrun;
    assign busy        = (r_state != S_IDLE);

endmodule

// File: tb/tb_note_judge.sv
// ---------------------------------------------------------------------------
// tb_note_judge -- directed self-checking bench for note_judge
// (default build, DEPTH=16, windows 1/3/5).
// ---------------------------------------------------------------------------
module tb_note_judge;

    logic        clk;
    logic        reset;
    logic        clear;
    logic        new_frame;
    logic [3:0]  DFJK;
    logic [15:0] un_time;
    logic        note_valid;
    logic [1:0]  note_lane;
    logic [15:0] note_time;
    logic        note_ready;
    logic        judge_valid;
    logic [1:0]  judge_lane;
    logic [1:0]  judge_grade;
    logic [19:0] score;
    logic [9:0]  combo;
    logic [9:0]  max_combo;
    logic        overrun;
    logic        busy;

    int total;
    int bad;

    // Judgements seen during the last frame task
    int         jcnt;
    logic [3:0] jv;
    logic [1:0] jg [0:3];

    note_judge dut (
        .clk        (clk),
        .reset      (reset),
        .clear      (clear),
        .new_frame  (new_frame),
        .DFJK       (DFJK),
        .un_time    (un_time),
        .note_valid (note_valid),
        .note_lane  (note_lane),
        .note_time  (note_time),
        .note_ready (note_ready),
        .judge_valid(judge_valid),
        .judge_lane (judge_lane),
        .judge_grade(judge_grade),
        .score      (score),
        .combo      (combo),
        .max_combo  (max_combo),
        .overrun    (overrun),
        .busy       (busy)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [1:0] lane, input logic [15:0] t);
        note_valid = 1'b1;
        note_lane  = lane;
        note_time  = t;
        tick();
        note_valid = 1'b0;
    endtask

    // One strobe followed by the full 4-lane scan; records judgements
    task automatic frame(input logic [3:0] keys, input logic [15:0] t);
        DFJK      = keys;
        un_time   = t;
        new_frame = 1'b1;
        tick();
        new_frame = 1'b0;
        chk("busy_scan", {31'd0, busy}, 32'd1);
        jcnt = 0;
        jv   = '0;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (judge_valid === 1'b1) begin
                jcnt++;
                jv[judge_lane] = 1'b1;
                jg[judge_lane] = judge_grade;
            end
        end
        chk("busy_end", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        total      = 0;
        bad        = 0;
        reset      = 1'b1;
        clear      = 1'b0;
        new_frame  = 1'b0;
        DFJK       = '0;
        un_time    = '0;
        note_valid = 1'b0;
        note_lane  = '0;
        note_time  = '0;
        for (int i = 0; i < 3; i++) tick();
        reset = 1'b0;
        tick();

        // Reset state
        chk("rst_ready",   {31'd0, note_ready},  32'd1);
        chk("rst_jvalid",  {31'd0, judge_valid}, 32'd0);
        chk("rst_score",   {12'd0, score},       32'd0);
        chk("rst_combo",   {22'd0, combo},       32'd0);
        chk("rst_max",     {22'd0, max_combo},   32'd0);
        chk("rst_overrun", {31'd0, overrun},     32'd0);
        chk("rst_busy",    {31'd0, busy},        32'd0);

        // PERFECT on lane 0 at exact time
        push(2'd0, 16'd100);
        frame(4'b0000, 16'd99);
        chk("p_none_before", jcnt, 0);
        frame(4'b0001, 16'd100);
        chk("p_cnt",   jcnt, 1);
        chk("p_lane0", {31'd0, jv[0]}, 32'd1);
        chk("p_grade", {30'd0, jg[0]}, 32'd3);
        chk("p_score", {12'd0, score}, 32'd300);
        chk("p_combo", {22'd0, combo}, 32'd1);
        chk("p_max",   {22'd0, max_combo}, 32'd1);
        frame(4'b0000, 16'd101);
        frame(4'b0001, 16'd102);
        chk("p_queue_empty", jcnt, 0);

        // GOOD on lane 1 at delta +5 (edge of window)
        push(2'd1, 16'd100);
        frame(4'b0000, 16'd103);
        chk("g_no_press", jcnt, 0);
        frame(4'b0010, 16'd105);
        chk("g_cnt",   jcnt, 1);
        chk("g_grade", {30'd0, jg[1]}, 32'd1);
        chk("g_score", {12'd0, score}, 32'd400);
        chk("g_combo", {22'd0, combo}, 32'd2);

        // Early press (delta -7) ignored, note retained, then PERFECT at -1
        push(2'd1, 16'd100);
        frame(4'b0000, 16'd93);
        frame(4'b0010, 16'd93);
        chk("early_ignored", jcnt, 0);
        frame(4'b0000, 16'd94);
        frame(4'b0010, 16'd99);
        chk("early_retained", jcnt, 1);
        chk("neg1_grade", {30'd0, jg[1]}, 32'd3);
        chk("neg1_score", {12'd0, score}, 32'd700);

        // Four lanes in one frame, lane 3 at delta +2 -> GREAT
        push(2'd0, 16'd200);
        push(2'd1, 16'd200);
        push(2'd2, 16'd200);
        push(2'd3, 16'd198);
        frame(4'b0000, 16'd198);
        chk("multi_none", jcnt, 0);
        frame(4'b1111, 16'd200);
        chk("multi_cnt",    jcnt, 4);
        chk("multi_g0",     {30'd0, jg[0]}, 32'd3);
        chk("multi_g3",     {30'd0, jg[3]}, 32'd2);
        chk("multi_score",  {12'd0, score}, 32'd1800);
        chk("multi_combo",  {22'd0, combo}, 32'd7);
        chk("multi_max",    {22'd0, max_combo}, 32'd7);

        // MISS on lane 2: delta 5 no action, delta 6 miss
        push(2'd2, 16'd50);
        frame(4'b0000, 16'd55);
        chk("miss_edge_none", jcnt, 0);
        frame(4'b0000, 16'd56);
        chk("miss_cnt",   jcnt, 1);
        chk("miss_lane2", {31'd0, jv[2]}, 32'd1);
        chk("miss_grade", {30'd0, jg[2]}, 32'd0);
        chk("miss_combo", {22'd0, combo}, 32'd0);
        chk("miss_max",   {22'd0, max_combo}, 32'd7);
        chk("miss_score", {12'd0, score}, 32'd1800);

        // Fill lane 3
        for (int i = 0; i < 15; i++) push(2'd3, 16'(1000 + i));
        note_lane = 2'd3;
        #1;
        chk("fill_ready15", {31'd0, note_ready}, 32'd1);
        push(2'd3, 16'd1015);
        note_lane = 2'd3;
        #1;
        chk("full_ready_l3", {31'd0, note_ready}, 32'd0);
        note_lane = 2'd0;
        #1;
        chk("full_ready_l0", {31'd0, note_ready}, 32'd1);

        // Push attempt while lane 3 is full and popping in the same cycle
        DFJK      = 4'b1000;
        un_time   = 16'd1000;
        new_frame = 1'b1;
        tick();
        new_frame = 1'b0;
        tick();
        tick();
        tick();
        note_valid = 1'b1;
        note_lane  = 2'd3;
        note_time  = 16'd2000;
        #1;
        chk("pp_ready_full", {31'd0, note_ready}, 32'd0);
        tick();
        note_valid = 1'b0;
        chk("pp_jvalid", {31'd0, judge_valid}, 32'd1);
        chk("pp_jlane",  {30'd0, judge_lane},  32'd3);
        chk("pp_jgrade", {30'd0, judge_grade}, 32'd3);
        chk("pp_rejected_ready", {31'd0, note_ready}, 32'd1);
        chk("pp_score", {12'd0, score}, 32'd2100);
        push(2'd3, 16'd1016);
        note_lane = 2'd3;
        #1;
        chk("pp_refill_full", {31'd0, note_ready}, 32'd0);

        // Held key: only the first frame judges
        push(2'd0, 16'd100);
        push(2'd0, 16'd101);
        frame(4'b0000, 16'd99);
        chk("hold_pre", jcnt, 0);
        frame(4'b0001, 16'd100);
        chk("hold_first", jcnt, 1);
        chk("hold_first_g", {30'd0, jg[0]}, 32'd3);
        chk("hold_score", {12'd0, score}, 32'd2400);
        frame(4'b0001, 16'd101);
        chk("hold_second", jcnt, 0);
        frame(4'b0001, 16'd106);
        chk("hold_edge", jcnt, 0);
        frame(4'b0001, 16'd107);
        chk("hold_miss_cnt", jcnt, 1);
        chk("hold_miss_g",   {30'd0, jg[0]}, 32'd0);
        chk("hold_combo",    {22'd0, combo}, 32'd0);
        chk("hold_overrun0", {31'd0, overrun}, 32'd0);

        // Back-to-back strobes -> overrun
        new_frame = 1'b1;
        tick();
        tick();
        new_frame = 1'b0;
        chk("ovr_set",  {31'd0, overrun}, 32'd1);
        chk("ovr_busy", {31'd0, busy}, 32'd1);
        for (int i = 0; i < 4; i++) tick();
        chk("ovr_idle", {31'd0, busy}, 32'd0);
        chk("ovr_sticky", {31'd0, overrun}, 32'd1);

        // Clear
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("clr_overrun", {31'd0, overrun}, 32'd0);
        chk("clr_score",   {12'd0, score}, 32'd0);
        chk("clr_combo",   {22'd0, combo}, 32'd0);
        chk("clr_max",     {22'd0, max_combo}, 32'd0);
        note_lane = 2'd3;
        #1;
        chk("clr_ready_l3", {31'd0, note_ready}, 32'd1);
        frame(4'b0000, 16'd2000);
        chk("clr_queues_empty", jcnt, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
